// File: rtl/sram_write_queue_if.sv
// Request/write-port bundle for sram_write_queue.
// The slave side is the queue itself; the master side is the game/render
// logic that issues writes and observes the controller-facing outputs.
interface sram_write_queue_if #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [LVL_W-1:0]  level;
  logic              idle;
  logic [15:0]       writes_done;

  modport slave (
    input  in_valid, in_addr, in_data,
    output in_ready, wr_en, wr_addr, wr_data, level, idle, writes_done
  );

  modport master (
    output in_valid, in_addr, in_data,
    input  in_ready, wr_en, wr_addr, wr_data, level, idle, writes_done
  );
endinterface

// File: rtl/sram_write_queue.sv
// Write-side feeder for the time-multiplexed SRAM controller.
// Buffers incoming writes in a FIFO and replays them as an 8-cycle pattern:
// wr_en high for EN_CYCLES, then low for HOLD_CYCLES, with address and data
// frozen across the whole window so any 4-phase controller slot samples each
// write exactly once without needing phase alignment.
module sram_write_queue #(
  parameter int DEPTH       = 16,
  parameter int ADDR_W      = 20,
  parameter int DATA_W      = 32,
  parameter int EN_CYCLES   = 4,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                 clk_100m,
  input  logic                 rst_n,
  sram_write_queue_if.slave    bus
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENTRY_W = ADDR_W + DATA_W;

  localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);
  localparam logic [2:0]       EN_LAST    = 3'(EN_CYCLES - 1);
  localparam logic [2:0]       HOLD_LAST  = 3'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    HOLD
  } state_t;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wrPtr_q;
  logic [PTR_W-1:0]   rdPtr_q;
  logic [LVL_W-1:0]   level_q, level_d;
  state_t             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic               wrEn_q, wrEn_d;
  logic [ADDR_W-1:0]  wrAddr_q, wrAddr_d;
  logic [DATA_W-1:0]  wrData_q, wrData_d;
  logic [15:0]        writesDone_q, writesDone_d;
  logic               push;
  logic               pop;
  logic               notEmpty;
  logic [ENTRY_W-1:0] headEntry;

  assign notEmpty  = (level_q != '0);
  assign push      = bus.in_valid && (level_q != FULL_LEVEL);
  assign headEntry = mem_q[rdPtr_q];

  assign bus.in_ready    = (level_q != FULL_LEVEL);
  assign bus.wr_en       = wrEn_q;
  assign bus.wr_addr     = wrAddr_q;
  assign bus.wr_data     = wrData_q;
  assign bus.level       = level_q;
  assign bus.idle        = (state_q == IDLE) && !notEmpty;
  assign bus.writes_done = writesDone_q;

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk_100m) begin
    if (push) begin
      mem_q[wrPtr_q] <= {bus.in_addr, bus.in_data};
    end
  end

  // Occupancy: a simultaneous push and pop cancel out.
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Pointers and occupancy; reset discards everything queued.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (pop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
      level_q <= level_d;
    end
  end

  // Drain sequencer: launch a write, hold enable, then hold address/data.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wrEn_d       = wrEn_q;
    wrAddr_d     = wrAddr_q;
    wrData_d     = wrData_q;
    writesDone_d = writesDone_q;
    pop          = 1'b0;
    case (state_q)
      IDLE: begin
        wrEn_d = 1'b0;
        if (notEmpty) begin
          pop      = 1'b1;
          wrAddr_d = headEntry[ENTRY_W-1:DATA_W];
          wrData_d = headEntry[DATA_W-1:0];
          wrEn_d   = 1'b1;
          cnt_d    = 3'd0;
          state_d  = ASSERT;
        end
      end
      ASSERT: begin
        if (cnt_q == EN_LAST) begin
          wrEn_d       = 1'b0;
          writesDone_d = writesDone_q + 16'd1;
          cnt_d        = 3'd0;
          state_d      = HOLD;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d = 3'd0;
          if (notEmpty) begin
            pop      = 1'b1;
            wrAddr_d = headEntry[ENTRY_W-1:DATA_W];
            wrData_d = headEntry[DATA_W-1:0];
            wrEn_d   = 1'b1;
            state_d  = ASSERT;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      default: begin
        state_d = IDLE;
        wrEn_d  = 1'b0;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // Sequencer registers; wr_en drops the moment reset asserts.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      wrEn_q       <= 1'b0;
      wrAddr_q     <= '0;
      wrData_q     <= '0;
      writesDone_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wrEn_q       <= wrEn_d;
      wrAddr_q     <= wrAddr_d;
      wrData_q     <= wrData_d;
      writesDone_q <= writesDone_d;
    end
  end

endmodule
